// File: rtl/pixel_mux.sv
// Per-dot pixel compositor and palette-port arbiter: builds the palette address
// for each visible dot, slots CPU palette writes into idle dots, and keeps the sprite-0 hit flag.
module pixel_mux #(
  parameter int H_VIS    = 256,
  parameter int V_VIS    = 240,
  parameter int PRE_LINE = 261
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  cycle,
  input  logic [8:0]  scanline,
  input  logic        bg_en,
  input  logic        spr_en,
  input  logic        bg_left_en,
  input  logic        spr_left_en,
  input  logic [3:0]  bg_pix,
  input  logic [3:0]  spr_pix,
  input  logic        spr_behind,
  input  logic        spr0_in,
  input  logic [13:0] vram_addr,
  input  logic        cpu_wr_req,
  input  logic [4:0]  cpu_wr_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_wr_ack,
  output logic [4:0]  pal_addr,
  output logic        pal_wr,
  output logic [7:0]  pal_data,
  output logic        pix_valid,
  output logic        sprite0_hit
);

  localparam logic [8:0] L_H_VIS    = 9'(H_VIS);
  localparam logic [8:0] L_V_VIS    = 9'(V_VIS);
  localparam logic [8:0] L_PRE_LINE = 9'(PRE_LINE);

  logic       w_vis;
  logic       w_rend;
  logic       w_clip;
  logic       w_bg_op;
  logic       w_sp_op;
  logic [4:0] w_pix_addr;
  logic [4:0] w_bd_addr;
  logic       w_grant;
  logic       w_hit_set;
  logic       w_hit_clr;

  logic       r_ack;
  logic [4:0] r_pal_addr;
  logic       r_pal_wr;
  logic [7:0] r_pal_data;
  logic       r_pix_valid;
  logic       r_hit;

  // Only v[13:8] and v[4:0] matter for the backdrop override.
  logic w_unused;
  assign w_unused = &{1'b0, vram_addr[7:5]};

  always_comb begin
    w_vis   = (cycle >= 9'd1) && (cycle <= L_H_VIS) && (scanline < L_V_VIS);
    w_rend  = bg_en | spr_en;
    w_clip  = (cycle <= 9'd8);
    w_bg_op = bg_en  & (bg_pix[1:0]  != 2'b00) & ~(w_clip & ~bg_left_en);
    w_sp_op = spr_en & (spr_pix[1:0] != 2'b00) & ~(w_clip & ~spr_left_en);

    w_pix_addr = 5'h00;
    case ({w_sp_op, w_bg_op})
      2'b10:   w_pix_addr = {1'b1, spr_pix};
      2'b01:   w_pix_addr = {1'b0, bg_pix};
      2'b11:   w_pix_addr = spr_behind ? {1'b0, bg_pix} : {1'b1, spr_pix};
      default: w_pix_addr = 5'h00;
    endcase

    w_bd_addr = (vram_addr[13:8] == 6'h3F) ? vram_addr[4:0] : 5'h00;

    // r_ack doubles as the pending flag, so grants are never back-to-back.
    w_grant   = cpu_wr_req & ~r_ack & ~(w_vis & w_rend);
    w_hit_set = w_vis & spr0_in & w_bg_op & w_sp_op & (cycle != 9'd255);
    w_hit_clr = (scanline == L_PRE_LINE) && (cycle == 9'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack       <= 1'b0;
      r_pal_addr  <= 5'h00;
      r_pal_wr    <= 1'b0;
      r_pal_data  <= 8'h00;
      r_pix_valid <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      r_ack <= w_grant;

      if (w_vis && w_rend) begin
        r_pix_valid <= 1'b1;
        r_pal_wr    <= 1'b0;
        r_pal_addr  <= w_pix_addr;
      end else if (w_grant) begin
        r_pix_valid <= 1'b0;
        r_pal_wr    <= 1'b1;
        r_pal_addr  <= cpu_wr_addr;
        r_pal_data  <= cpu_wr_data;
      end else if (w_vis) begin
        r_pix_valid <= 1'b1;
        r_pal_wr    <= 1'b0;
        r_pal_addr  <= w_bd_addr;
      end else begin
        r_pix_valid <= 1'b0;
        r_pal_wr    <= 1'b0;
      end

      // Clear has priority over a set on the same dot.
      if (w_hit_clr) begin
        r_hit <= 1'b0;
      end else if (w_hit_set) begin
        r_hit <= 1'b1;
      end
    end
  end

  assign cpu_wr_ack  = r_ack;
  assign pal_addr    = r_pal_addr;
  assign pal_wr      = r_pal_wr;
  assign pal_data    = r_pal_data;
  assign pix_valid   = r_pix_valid;
  assign sprite0_hit = r_hit;

endmodule

// File: doc/pixel_mux.md
Name: pixel_mux

Overview:
- Per-dot pixel compositor and palette-port arbiter for the PPU.
- Each dot it combines the background and sprite pixel streams, applying left-edge clipping and sprite priority, and produces the 5-bit palette address.
- It keeps the sticky sprite-0 hit flag.
- It grants CPU palette writes on dots where no pixel lookup is needed.
- It drives the palette RAM address, write strobe and write data directly. Downstream colour output samples palette data one cycle after pix_valid.

Parameters:
H_VIS, 256, visible dots per line (dots 1..H_VIS)
V_VIS, 240, visible scanlines (0..V_VIS-1)
PRE_LINE, 261, pre-render scanline number

Ports:
clk  in  1  PPU dot clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
cycle  in  9  current dot 0..340
scanline  in  9  current line 0..261
bg_en  in  1  background rendering enable
spr_en  in  1  sprite rendering enable
bg_left_en  in  1  show background in dots 1..8
spr_left_en  in  1  show sprites in dots 1..8
bg_pix  in  4  {palette[1:0], pattern[1:0]} for this dot
spr_pix  in  4  {palette[1:0], pattern[1:0]} of front sprite
spr_behind  in  1  front sprite priority bit (1 = behind background)
spr0_in  in  1  front sprite is OAM sprite 0
vram_addr  in  14  current v register
cpu_wr_req  in  1  CPU palette write request (level)
cpu_wr_addr  in  5  CPU palette address
cpu_wr_data  in  8  CPU write data
cpu_wr_ack  out  1  one-cycle write-accepted pulse
pal_addr  out  5  palette RAM address (registered)
pal_wr  out  1  palette RAM write strobe (registered)
pal_data  out  8  palette RAM write data (registered)
pix_valid  out  1  pal_addr is a pixel lookup for this dot
sprite0_hit  out  1  sticky sprite-0 hit flag

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0. Internal ack state cleared. Reset mid-write drops the write; no ack is issued.
- vis = (1 <= cycle <= H_VIS) and (scanline < V_VIS). rend = bg_en | spr_en. clip = cycle <= 8.
- bg_op = bg_en & (bg_pix[1:0] != 0) & ~(clip & ~bg_left_en).
- sp_op = spr_en & (spr_pix[1:0] != 0) & ~(clip & ~spr_left_en).
- Pixel address selection:
  - Neither opaque: 5'h00.
  - sp_op only: {1, spr_pix}.
  - bg_op only: {0, bg_pix}.
  - Both opaque: {1, spr_pix} if spr_behind=0, else {0, bg_pix}.
- Rendering off (vis & ~rend): address = vram_addr[4:0] if vram_addr[13:8] == 6'h3F, else 5'h00.
- Arbitration, combinational on inputs, result registered at the next clock:
  - vis & rend: pixel slot. pix_valid<=1, pal_wr<=0, pal_addr<=pixel address. CPU request waits.
  - vis & ~rend & cpu_wr_req & ~ack_pend: CPU slot. pal_wr<=1, pix_valid<=0. Downstream holds the previous colour.
  - vis & ~rend, no granted write: pix_valid<=1 with the backdrop/v address.
  - ~vis & cpu_wr_req & ~ack_pend: pal_wr<=1, pal_addr<=cpu_wr_addr, pal_data<=cpu_wr_data.
  - Otherwise: pal_wr<=0, pix_valid<=0, pal_addr holds its value.
- Latency: dot inputs sampled at edge N appear on pal_addr/pix_valid after edge N. Palette data is valid after edge N+1.
- Handshake:
  - cpu_wr_ack is registered and asserted in the same cycle as the pal_wr it causes.
  - ack_pend is set with the ack and cleared the cycle after. No back-to-back grants, so at most one write per 2 cycles.
  - The requester drops cpu_wr_req on seeing ack. Req still high after ack_pend clears is treated as a new write.
  - Address and data must be stable while req is high.
- Sprite-0 hit:
  - Set when vis & spr0_in & bg_op & sp_op & (cycle != 255), independent of spr_behind.
  - Stays set, with no clear during visible lines.
  - Cleared on scanline == PRE_LINE & cycle == 1. Clear wins over a simultaneous set.
  - Registered; visible 1 cycle after the qualifying dot.

Test Plan:
- Priority: dot 100, line 10, bg_en=spr_en=1, bg_pix=4'h6, spr_pix=4'hB → spr_behind=0 gives pal_addr=5'h1B, pix_valid=1 next cycle; spr_behind=1 gives 5'h06; bg_pix=4'h4 with spr_behind=1 gives 5'h1B.
- Clipping: dot 5, bg_left_en=0, spr_left_en=1, bg_pix=4'h7, spr_pix=4'h0 → 5'h00; spr0_in=1 with spr_pix=4'h1 gives no hit; repeat at dot 9 → hit set.
- Sprite-0 hit: qualifying overlap at dot 255 → no hit; same at dot 254 → sprite0_hit=1 one cycle later; it holds through line 239; clears at line 261 dot 1; a simultaneous qualifying set there still leaves it 0.
- CPU write arbitration: req asserted at line 20 dot 50 with rendering on → no ack until dot 257; then pal_wr=1, pal_addr=cpu_wr_addr, data 8'h2C, ack one cycle; req held high → second ack exactly 2 cycles later.
- Rendering off: bg_en=spr_en=0, vram_addr=14'h3F07, dot 10 → pal_addr=5'h07, pix_valid=1; vram_addr=14'h2000 → 5'h00; CPU req on a visible dot → pal_wr=1, pix_valid=0 that cycle.
- Reset: drive rst=0 asynchronously during a granted write → all outputs 0 immediately, no ack; after release, a pending req is re-granted normally.
